// File: rtl/traffic_pkg.sv
// traffic_pkg: shared codes and widths for the traffic mode controller (NIGHT_MODE_EN adds the night state)
package traffic_pkg;

    localparam int TW = 7;
    localparam int CW = 16;

    typedef enum logic [2:0] {
        SEQ_GR = 3'd3,
        SEQ_YR = 3'd4,
        SEQ_RG = 3'd5,
        SEQ_RY = 3'd6
    } seq_e;

    typedef enum logic [1:0] {
        L_OFF = 2'd0,
        L_RED = 2'd1,
        L_YEL = 2'd2,
        L_GRN = 2'd3
    } light_e;

    typedef enum logic [1:0] {
        M_AUTO   = 2'd0,
        M_NIGHT  = 2'd1,
        M_MANUAL = 2'd2,
        M_TRANS  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_AUTO,
        ST_DRAIN,
        ST_CLEAR,
`ifdef NIGHT_MODE_EN
        ST_MANUAL,
        ST_NIGHT
`else
        ST_MANUAL
`endif
    } ctrl_e;

    function automatic logic mode_ok(input logic [1:0] m);
`ifdef NIGHT_MODE_EN
        return m != 2'd3;
`else
        return m == 2'd0 || m == 2'd2;
`endif
    endfunction

endpackage

// File: rtl/traffic_mode_ctrl_if.sv
// traffic_mode_ctrl_if: request, config and sequencer signals of the mode controller
interface traffic_mode_ctrl_if;
    import traffic_pkg::*;

    logic [1:0]    mode_sel;
    logic          manual_step;
    logic          cfg_we;
    logic [TW-1:0] cfg_green;
    logic [TW-1:0] cfg_yellow;
    logic [TW-1:0] cfg_red;
    logic [2:0]    seq_state;
    logic [TW-1:0] seq_time1;
    logic [TW-1:0] seq_time2;
    logic          seq_enable;
    logic [TW-1:0] green_time;
    logic [TW-1:0] yellow_time;
    logic [TW-1:0] red_time;
    logic          ovr;
    logic [1:0]    light1;
    logic [1:0]    light2;
    logic [1:0]    mode_active;
    logic          cfg_pending;
    logic          cfg_err;

    modport master (
        output mode_sel, manual_step, cfg_we, cfg_green, cfg_yellow, cfg_red,
               seq_state, seq_time1, seq_time2,
        input  seq_enable, green_time, yellow_time, red_time, ovr, light1, light2,
               mode_active, cfg_pending, cfg_err
    );

    modport slave (
        input  mode_sel, manual_step, cfg_we, cfg_green, cfg_yellow, cfg_red,
               seq_state, seq_time1, seq_time2,
        output seq_enable, green_time, yellow_time, red_time, ovr, light1, light2,
               mode_active, cfg_pending, cfg_err
    );

endinterface

// File: rtl/traffic_cfg_shadow.sv
// traffic_cfg_shadow: validates timing writes, holds them in a shadow until commit, drives active times
module traffic_cfg_shadow
    import traffic_pkg::*;
#(
    parameter int DEF_GREEN  = 20,
    parameter int DEF_YELLOW = 3,
    parameter int DEF_RED    = 23
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we_i,
    input  logic [TW-1:0] cfg_green_i,
    input  logic [TW-1:0] cfg_yellow_i,
    input  logic [TW-1:0] cfg_red_i,
    input  logic          commit_i,
    output logic [TW-1:0] green_time_o,
    output logic [TW-1:0] yellow_time_o,
    output logic [TW-1:0] red_time_o,
    output logic          cfg_pending_o,
    output logic          cfg_err_o
);

    logic [TW-1:0] sh_g_q, sh_y_q, sh_r_q;
    logic [TW-1:0] act_g_q, act_y_q, act_r_q;
    logic          pend_q, err_q, ok, acc;

    // a write is usable only with all fields nonzero and green+yellow equal to red in 8 bits
    always_comb begin
        ok  = |cfg_green_i && |cfg_yellow_i && |cfg_red_i &&
              ({1'b0, cfg_green_i} + {1'b0, cfg_yellow_i} == {1'b0, cfg_red_i});
        acc = cfg_we_i && ok;
    end

    // commit takes the old shadow even when a new write lands in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_g_q  <= TW'(DEF_GREEN);
            sh_y_q  <= TW'(DEF_YELLOW);
            sh_r_q  <= TW'(DEF_RED);
            act_g_q <= TW'(DEF_GREEN);
            act_y_q <= TW'(DEF_YELLOW);
            act_r_q <= TW'(DEF_RED);
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (commit_i) begin
                act_g_q <= sh_g_q;
                act_y_q <= sh_y_q;
                act_r_q <= sh_r_q;
            end
            if (acc) begin
                sh_g_q <= cfg_green_i;
                sh_y_q <= cfg_yellow_i;
                sh_r_q <= cfg_red_i;
            end
            pend_q <= acc || (pend_q && !commit_i);
            err_q  <= cfg_we_i && !ok;
        end
    end

    assign green_time_o  = act_g_q;
    assign yellow_time_o = act_y_q;
    assign red_time_o    = act_r_q;
    assign cfg_pending_o = pend_q;
    assign cfg_err_o     = err_q;

endmodule

// File: rtl/traffic_mode_ctrl.sv
// traffic_mode_ctrl: sequences auto/manual operation with safe handover and all-red clearance (NIGHT_MODE_EN adds night flash)
module traffic_mode_ctrl
    import traffic_pkg::*;
#(
    parameter int CLEAR_CYCLES = 3,
    parameter int MAN_YELLOW   = 3,
    parameter int DEF_GREEN    = 20,
    parameter int DEF_YELLOW   = 3,
    parameter int DEF_RED      = 23,
    parameter int FLASH_HALF   = 1
) (
    input logic              clk,
    input logic              reset,
    traffic_mode_ctrl_if.slave bus
);

    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] MY_LAST  = CW'(MAN_YELLOW - 1);

    ctrl_e         st_q, st_d, entry;
    mode_e         tgt_q;
    seq_e          ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_q, step_rise, boundary, commit, pend, run;
`ifdef NIGHT_MODE_EN
    logic          fl_q, fl_d;
`endif

    traffic_cfg_shadow #(
        .DEF_GREEN (DEF_GREEN),
        .DEF_YELLOW(DEF_YELLOW),
        .DEF_RED   (DEF_RED)
    ) u_cfg (
        .clk          (clk),
        .reset        (reset),
        .cfg_we_i     (bus.cfg_we),
        .cfg_green_i  (bus.cfg_green),
        .cfg_yellow_i (bus.cfg_yellow),
        .cfg_red_i    (bus.cfg_red),
        .commit_i     (commit),
        .green_time_o (bus.green_time),
        .yellow_time_o(bus.yellow_time),
        .red_time_o   (bus.red_time),
        .cfg_pending_o(pend),
        .cfg_err_o    (bus.cfg_err)
    );

    // state, counters, target capture and step edge detector
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= ST_INIT;
            cnt_q  <= '0;
            ph_q   <= SEQ_GR;
            tgt_q  <= M_AUTO;
            step_q <= 1'b0;
`ifdef NIGHT_MODE_EN
            fl_q   <= 1'b1;
`endif
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            ph_q   <= ph_d;
            tgt_q  <= mode_ok(bus.mode_sel) ? mode_e'(bus.mode_sel) : tgt_q;
            step_q <= bus.manual_step;
`ifdef NIGHT_MODE_EN
            fl_q   <= fl_d;
`endif
        end
    end

    // next state: handover waits for a yellow-end boundary, every mode change passes through clearance
    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        ph_d      = ph_q;
        commit    = 1'b0;
        step_rise = bus.manual_step && !step_q;
        boundary  = (bus.seq_state == SEQ_YR && bus.seq_time1 == TW'(1)) ||
                    (bus.seq_state == SEQ_RY && bus.seq_time2 == TW'(1));
`ifdef NIGHT_MODE_EN
        fl_d      = fl_q;
        entry     = tgt_q == M_MANUAL ? ST_MANUAL : tgt_q == M_NIGHT ? ST_NIGHT : ST_AUTO;
`else
        entry     = tgt_q == M_MANUAL ? ST_MANUAL : ST_AUTO;
`endif
        case (st_q)
            ST_INIT, ST_CLEAR: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CLR_LAST) begin
                    commit = pend;
                    st_d   = entry;
                    cnt_d  = '0;
                    ph_d   = SEQ_GR;
`ifdef NIGHT_MODE_EN
                    fl_d   = 1'b1;
`endif
                end
            end
            ST_AUTO: st_d = (tgt_q != M_AUTO || pend) ? ST_DRAIN : ST_AUTO;
            ST_DRAIN: begin
                if (boundary) begin
                    st_d  = ST_CLEAR;
                    cnt_d = '0;
                end else if (tgt_q == M_AUTO && !pend) begin
                    st_d = ST_AUTO;
                end
            end
            ST_MANUAL: begin
                commit = pend;
                if (ph_q == SEQ_GR || ph_q == SEQ_RG) begin
                    if (tgt_q != M_MANUAL || step_rise) begin
                        ph_d  = ph_q == SEQ_GR ? SEQ_YR : SEQ_RY;
                        cnt_d = '0;
                    end
                end else if (cnt_q == MY_LAST) begin
                    cnt_d = '0;
                    ph_d  = ph_q == SEQ_YR ? SEQ_RG : SEQ_GR;
                    st_d  = tgt_q != M_MANUAL ? ST_CLEAR : ST_MANUAL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef NIGHT_MODE_EN
            ST_NIGHT: begin
                commit = pend;
                cnt_d  = cnt_q + CW'(1);
                if (tgt_q != M_NIGHT) begin
                    st_d  = ST_CLEAR;
                    cnt_d = '0;
                end else if (cnt_q == CW'(FLASH_HALF - 1)) begin
                    cnt_d = '0;
                    fl_d  = !fl_q;
                end
            end
`endif
            default: st_d = ST_INIT;
        endcase
    end

    // outputs decode from registered state only; lights default to all red
    always_comb begin
        run             = st_q == ST_AUTO || st_q == ST_DRAIN;
        bus.seq_enable  = run;
        bus.ovr         = !run;
        bus.cfg_pending = pend;
        bus.mode_active = run ? M_AUTO : M_TRANS;
        bus.light1      = L_RED;
        bus.light2      = L_RED;
        if (st_q == ST_MANUAL) begin
            bus.mode_active = M_MANUAL;
            bus.light1      = ph_q == SEQ_GR ? L_GRN : ph_q == SEQ_YR ? L_YEL : L_RED;
            bus.light2      = ph_q == SEQ_RG ? L_GRN : ph_q == SEQ_RY ? L_YEL : L_RED;
        end
`ifdef NIGHT_MODE_EN
        if (st_q == ST_NIGHT) begin
            bus.mode_active = M_NIGHT;
            bus.light1      = fl_q ? L_YEL : L_OFF;
            bus.light2      = fl_q ? L_YEL : L_OFF;
        end
`endif
    end

endmodule

// File: tb/tb_traffic_mode_ctrl.sv
// tb_traffic_mode_ctrl: directed checks of startup, config shadowing, handover, manual stepping and night/hold behaviour
module tb_traffic_mode_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    traffic_mode_ctrl_if bus();

    traffic_mode_ctrl #(
        .CLEAR_CYCLES(3),
        .MAN_YELLOW  (3),
        .DEF_GREEN   (20),
        .DEF_YELLOW  (3),
        .DEF_RED     (23),
        .FLASH_HALF  (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int en, input int l1, input int l2, input int ma);
        chk({tag, ".seq_enable"}, 32'(bus.seq_enable), 32'(en));
        chk({tag, ".ovr"}, 32'(bus.ovr), 32'(en == 0));
        if (en == 0) begin
            chk({tag, ".light1"}, 32'(bus.light1), 32'(l1));
            chk({tag, ".light2"}, 32'(bus.light2), 32'(l2));
        end
        chk({tag, ".mode_active"}, 32'(bus.mode_active), 32'(ma));
    endtask

    task automatic chk_times(input string tag, input int g, input int y, input int r, input int p);
        chk({tag, ".green"}, 32'(bus.green_time), 32'(g));
        chk({tag, ".yellow"}, 32'(bus.yellow_time), 32'(y));
        chk({tag, ".red"}, 32'(bus.red_time), 32'(r));
        chk({tag, ".pending"}, 32'(bus.cfg_pending), 32'(p));
    endtask

    task automatic cfg(input logic we, input int g, input int y, input int r);
        bus.cfg_we     = we;
        bus.cfg_green  = 7'(g);
        bus.cfg_yellow = 7'(y);
        bus.cfg_red    = 7'(r);
    endtask

    task automatic seq(input int s, input int t1, input int t2);
        bus.seq_state = 3'(s);
        bus.seq_time1 = 7'(t1);
        bus.seq_time2 = 7'(t2);
    endtask

    initial begin
        bus.mode_sel    = 2'd0;
        bus.manual_step = 1'b0;
        cfg(1'b0, 0, 0, 0);
        seq(3, 5, 5);
        tick();
        tick();
        chk_out("reset", 0, 1, 1, 3);
        chk_times("reset", 20, 3, 23, 0);
        chk("reset.cfg_err", 32'(bus.cfg_err), 0);
        reset = 1'b0;
        tick();
        chk_out("init2", 0, 1, 1, 3);
        tick();
        chk_out("init3", 0, 1, 1, 3);
        tick();
        chk_out("auto_start", 1, 0, 0, 0);
        chk_times("auto_start", 20, 3, 23, 0);

        cfg(1'b1, 10, 2, 12);
        tick();
        cfg(1'b0, 0, 0, 0);
        chk_times("write_ok", 20, 3, 23, 1);
        chk_out("write_ok", 1, 0, 0, 0);
        tick();
        chk_out("drain", 1, 0, 0, 0);
        seq(4, 1, 9);
        tick();
        seq(3, 9, 9);
        chk_out("clr1", 0, 1, 1, 3);
        chk_times("clr1", 20, 3, 23, 1);
        tick();
        chk_out("clr2", 0, 1, 1, 3);
        tick();
        chk_out("clr3", 0, 1, 1, 3);
        tick();
        chk_out("auto_new", 1, 0, 0, 0);
        chk_times("auto_new", 10, 2, 12, 0);

        cfg(1'b1, 10, 2, 13);
        tick();
        chk("rej_sum.cfg_err", 32'(bus.cfg_err), 1);
        cfg(1'b1, 0, 2, 2);
        tick();
        chk("rej_zero.cfg_err", 32'(bus.cfg_err), 1);
        cfg(1'b0, 0, 0, 0);
        tick();
        chk("rej_done.cfg_err", 32'(bus.cfg_err), 0);
        chk_times("rej_done", 10, 2, 12, 0);
        chk_out("rej_done", 1, 0, 0, 0);

        bus.mode_sel = 2'd2;
        seq(3, 8, 9);
        tick();
        chk_out("to_man_a", 1, 0, 0, 0);
        tick();
        chk_out("to_man_b", 1, 0, 0, 0);
        seq(4, 2, 9);
        tick();
        chk_out("to_man_c", 1, 0, 0, 0);
        seq(4, 1, 9);
        tick();
        seq(3, 9, 9);
        chk_out("mclr1", 0, 1, 1, 3);
        tick();
        chk_out("mclr2", 0, 1, 1, 3);
        tick();
        chk_out("mclr3", 0, 1, 1, 3);
        tick();
        chk_out("man_gr", 0, 3, 1, 2);

        cfg(1'b1, 5, 1, 6);
        tick();
        chk_times("man_w1", 10, 2, 12, 1);
        cfg(1'b1, 7, 1, 8);
        tick();
        cfg(1'b0, 0, 0, 0);
        chk_times("man_c1", 5, 1, 6, 1);
        tick();
        chk_times("man_c2", 7, 1, 8, 0);
        chk_out("man_c2", 0, 3, 1, 2);

        bus.manual_step = 1'b1;
        tick();
        chk_out("yr1", 0, 2, 1, 2);
        bus.manual_step = 1'b0;
        tick();
        chk_out("yr2", 0, 2, 1, 2);
        bus.manual_step = 1'b1;
        tick();
        chk_out("yr3", 0, 2, 1, 2);
        bus.manual_step = 1'b0;
        tick();
        chk_out("rg1", 0, 1, 3, 2);
        tick();
        chk_out("rg2", 0, 1, 3, 2);

        bus.mode_sel = 2'd0;
        tick();
        chk_out("rg_leave", 0, 1, 3, 2);
        tick();
        chk_out("ry1", 0, 1, 2, 2);
        tick();
        chk_out("ry2", 0, 1, 2, 2);
        tick();
        chk_out("ry3", 0, 1, 2, 2);
        tick();
        chk_out("aclr1", 0, 1, 1, 3);
        tick();
        chk_out("aclr2", 0, 1, 1, 3);
        tick();
        chk_out("aclr3", 0, 1, 1, 3);
        tick();
        chk_out("auto_back", 1, 0, 0, 0);
        chk_times("auto_back", 7, 1, 8, 0);

        bus.mode_sel = 2'd1;
        tick();
        tick();
        seq(6, 9, 1);
        tick();
        seq(3, 9, 9);
`ifdef NIGHT_MODE_EN
        chk_out("nclr1", 0, 1, 1, 3);
        tick();
        chk_out("nclr2", 0, 1, 1, 3);
        tick();
        chk_out("nclr3", 0, 1, 1, 3);
        tick();
        chk_out("night1", 0, 2, 2, 1);
        tick();
        chk_out("night2", 0, 0, 0, 1);
        tick();
        chk_out("night3", 0, 2, 2, 1);
`else
        chk_out("night_hold1", 1, 0, 0, 0);
        tick();
        chk_out("night_hold2", 1, 0, 0, 0);
`endif

        reset = 1'b1;
        tick();
        chk_out("mid_reset", 0, 1, 1, 3);
        chk_times("mid_reset", 20, 3, 23, 0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_mode_ctrl.md
Name: traffic_mode_ctrl

Overview:
Mode controller that sequences the two-lane auto sequencer (states GR=3, YR=4, RG=5, RY=6) and owns its timing configuration.
- Selects AUTO, MANUAL or (optional) NIGHT operation.
- Switches modes only at safe yellow-end boundaries, followed by an all-red clearance interval.
- Validates and shadows green/yellow/red time writes.
- Drives light overrides whenever the sequencer is not in control.

Parameters:
CLEAR_CYCLES, 3, all-red clearance length in cycles (>=1)
MAN_YELLOW, 3, yellow dwell in manual mode, cycles (>=1)
DEF_GREEN, 20, reset value of active green time
DEF_YELLOW, 3, reset value of active yellow time
DEF_RED, 23, reset value of active red time (=DEF_GREEN+DEF_YELLOW)
FLASH_HALF, 1, night flash half-period, cycles

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mode_sel  in  2  requested mode: 0 auto, 1 night, 2 manual, 3 invalid (hold current)
manual_step  in  1  manual advance request, edge-detected internally
cfg_we  in  1  single-cycle config write strobe
cfg_green / cfg_yellow / cfg_red  in  7 each  proposed times
seq_state  in  3  sequencer state
seq_time1 / seq_time2  in  7 each  sequencer lane countdowns
seq_enable  out  1  sequencer enable; sequencer reloads on 0->1
green_time / yellow_time / red_time  out  7 each  active config to sequencer
ovr  out  1  1 = light1/light2 valid and override sequencer display
light1 / light2  out  2 each  0 off, 1 red, 2 yellow, 3 green
mode_active  out  2  0 auto, 1 night, 2 manual, 3 transition
cfg_pending  out  1  validated write waiting to commit
cfg_err  out  1  one-cycle pulse on rejected write

Behaviour:
Reset values:
- seq_enable=0; active times = DEF_*; ovr=1; light1=light2=1 (red); mode_active=3; cfg_pending=0; cfg_err=0.
- Controller state = INIT with clear counter = 0.

States: INIT, AUTO, DRAIN, CLEAR, MANUAL, NIGHT.
- INIT behaves as CLEAR: all red for CLEAR_CYCLES cycles, then enters the target mode.

Target mode:
- mode_sel is registered every cycle; code 3 keeps the previous target.

AUTO:
- seq_enable=1, ovr=0.
- A target != auto, or cfg_pending=1, moves to DRAIN.

DRAIN:
- seq_enable stays 1.
- boundary = (seq_state==4 && seq_time1==1) || (seq_state==6 && seq_time2==1).
- On boundary, the next edge sets seq_enable=0 and enters CLEAR.
- If the target returns to auto and no config is pending before the boundary, go back to AUTO with no interruption.

CLEAR:
- ovr=1, both lights red, mode_active=3, for exactly CLEAR_CYCLES cycles.
- On exit, a pending config commits, then the controller enters the target mode.
- Entering AUTO raises seq_enable the cycle after exit, so the sequencer sees a 0->1 edge.

MANUAL:
- ovr=1. Entry phase is GR (light1 green, light2 red).
- Step in GR -> YR for MAN_YELLOW cycles -> RG.
- Step in RG -> RY for MAN_YELLOW cycles -> GR.
- Steps during a yellow phase are ignored.
- When the target changes away from manual:
  - from a green phase: force the corresponding yellow for MAN_YELLOW cycles, then CLEAR;
  - from a yellow phase: finish the yellow, then CLEAR.
- A pending config commits the next cycle.

NIGHT:
- ovr=1. Both lights are yellow for FLASH_HALF cycles, then off for FLASH_HALF cycles, repeating; first half is yellow.
- Target change goes straight to CLEAR.
- A pending config commits the next cycle.

Config validation, on cfg_we:
- Accept only if green, yellow and red are all nonzero and the 8-bit sum green+yellow equals red.
- Accept: load the shadow registers and set cfg_pending.
- Reject: cfg_err=1 for one cycle; shadow and pending are unchanged.
- A new write while pending overwrites the shadow.
- Commit copies shadow to active and clears cfg_pending.
- cfg_we in the same cycle as a commit: the commit uses the old shadow, the new write stays pending.

Simultaneous events:
- mode_sel and cfg_we in the same cycle are both captured.
- A boundary and a target change in the same cycle while in AUTO: enter DRAIN and wait for the next boundary.

Reset mid-operation: all outputs return to reset values next edge; INIT restarts.

Optional Feature:
NIGHT_MODE_EN
- Defined: NIGHT state and flashing behaviour present; mode_sel=1 is valid.
- Undefined: NIGHT state absent; mode_sel=1 treated as invalid (hold); mode_active never equals 1.

Decomposition:
- Shared package/include traffic_pkg holds:
  - sequencer state codes GR/YR/RG/RY (3..6);
  - light codes;
  - mode codes;
  - controller state encoding;
  - 7-bit time width constant.
- One natural sub-module, traffic_cfg_shadow: validation, shadow and active registers, pending flag, cfg_err pulse, commit input.

Test Plan:
- Reset, mode_sel=0, defaults -> lights red, seq_enable=0 for 3 cycles; seq_enable=1 on cycle 4 with 20/3/23 on the time outputs.
- In AUTO, write 10/2/12 -> cfg_pending=1; at next YR time1==1, seq_enable drops; 3 red cycles; seq_enable re-rises with 10/2/12; cfg_pending=0.
- Write 10/2/13, then 0/2/2 -> cfg_err pulses once per write; active times unchanged; cfg_pending stays 0.
- AUTO mid-GR, set mode_sel=2 -> stays in AUTO until yellow-end boundary; 3 clear cycles; MANUAL with light1=3, light2=1.
- MANUAL: step -> light1=2 for 3 cycles (a step in cycle 2 is ignored) -> light1=1, light2=3; set mode_sel=0 in RG -> 3 cycles light2=2, then CLEAR, then AUTO.
- With NIGHT_MODE_EN and FLASH_HALF=1, mode_sel=1 -> after clear, both lights alternate 2/0 each cycle; without the macro, mode_sel=1 leaves the mode unchanged.
